// File: rtl/matrix_result_writeback_if.sv
// Memory write-port bundle between the result writeback block and the dpmem.
// master = writeback side (drives address/data/write), slave = memory side.
interface matrix_result_writeback_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] dpmem_addr_a;
  logic [DATA_WIDTH-1:0] dpmem_din_a;
  logic                  dpmem_we_a;
  logic                  dpmem_wr_ready;

  modport master (output dpmem_addr_a, output dpmem_din_a, output dpmem_we_a,
                  input  dpmem_wr_ready);
  modport slave  (input  dpmem_addr_a, input  dpmem_din_a, input  dpmem_we_a,
                  output dpmem_wr_ready);
endinterface

// File: rtl/matrix_result_writeback.sv
// Captures the 8x8 FMA result matrix on wb_start and streams it into the
// dual-port memory as 64-bit words, stalling on dpmem_wr_ready.
// Optional macro FMA_WB_SAT8_EN: saturate each element to signed 8 bits and
// pack one row per word (matrix-B operand layout), 8 words instead of 24.
module matrix_result_writeback #(
  parameter int ACCUMULATOR_WIDTH = 24,
  parameter int ADDR_WIDTH        = 8,
  parameter int DATA_WIDTH        = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wb_start,
  input  logic [ADDR_WIDTH-1:0]          wb_base_addr,
  input  logic [64*ACCUMULATOR_WIDTH-1:0] mat_res,
  output logic                           wb_busy,
  output logic                           wb_done,
  matrix_result_writeback_if.master      mem
);
  localparam int NUM_EL = 64;
`ifdef FMA_WB_SAT8_EN
  localparam int NUM_WORDS = 8;
`else
  localparam int NUM_WORDS = NUM_EL * ACCUMULATOR_WIDTH / DATA_WIDTH;
`endif
  localparam int KW = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                               state, state_d;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] cap, cap_d;
  logic [ADDR_WIDTH-1:0]                base;
  logic [KW-1:0]                        k;
  logic                                 accept, last;

`ifdef FMA_WB_SAT8_EN
  localparam logic signed [ACCUMULATOR_WIDTH-1:0] SAT_HI = 127;
  localparam logic signed [ACCUMULATOR_WIDTH-1:0] SAT_LO = -128;

  function automatic logic [7:0] sat8(input logic signed [ACCUMULATOR_WIDTH-1:0] v);
    if (v > SAT_HI) return 8'h7f;
    if (v < SAT_LO) return 8'h80;
    return v[7:0];
  endfunction

  // Saturation is applied before capture so only 512 bits are stored.
  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      assign cap_d[r][c*8 +: 8] = sat8(mat_res[(r*8+c)*ACCUMULATOR_WIDTH +: ACCUMULATOR_WIDTH]);
    end
  end
`else
  // Raw layout: the flat result vector is simply cut into 64-bit words.
  assign cap_d = mat_res;
`endif

  assign accept = (state == WRITE) && mem.dpmem_wr_ready;
  assign last   = (k == KW'(NUM_WORDS - 1));

  assign mem.dpmem_addr_a = base + ADDR_WIDTH'(k);
  assign mem.dpmem_din_a  = cap[k];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d        = state;
    mem.dpmem_we_a = 1'b0;
    wb_busy        = 1'b0;
    wb_done        = 1'b0;
    case (state)
      IDLE:  if (wb_start) state_d = WRITE;
      WRITE: begin
        mem.dpmem_we_a = 1'b1;
        wb_busy        = 1'b1;
        if (accept && last) state_d = DONE;
      end
      DONE: begin
        wb_busy = 1'b1;
        wb_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture on start (IDLE only); word counter advances on each accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap  <= '0;
      base <= '0;
      k    <= '0;
    end else if (state == IDLE && wb_start) begin
      cap  <= cap_d;
      base <= wb_base_addr;
      k    <= '0;
    end else if (accept) begin
      k <= last ? '0 : k + 1'b1;
    end
  end
endmodule

// File: tb/tb_matrix_result_writeback.sv
// Directed bench for matrix_result_writeback with a scoreboard of expected
// memory writes derived from element values, plus literal pins.
module tb_matrix_result_writeback;
`ifdef FMA_WB_SAT8_EN
  localparam int NW = 8;
  localparam logic [63:0] PIN_W0    = 64'h0706050403020100;
  localparam logic [63:0] PIN_W1    = 64'h0f0e0d0c0b0a0908;
  localparam logic [63:0] PIN_NEG   = 64'h00000000FB807F3A;
  localparam logic [7:0]  WRAP_BASE = 8'hFC;
  localparam int          WRAP_IDX0 = 4;
  localparam logic [7:0]  PIN_LASTA = 8'h17;
`else
  localparam int NW = 24;
  localparam logic [63:0] PIN_W0    = 64'h0002000001000000;
  localparam logic [63:0] PIN_W1    = 64'h0500000400000300;
  localparam logic [63:0] PIN_NEG   = 64'hFE0C00012C00003A;
  localparam logic [7:0]  WRAP_BASE = 8'hF0;
  localparam int          WRAP_IDX0 = 16;
  localparam logic [7:0]  PIN_LASTA = 8'h27;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wb_start = 1'b0;
  logic [7:0]    wb_base_addr = '0;
  logic [1535:0] mat_res = '0;
  logic          wb_busy, wb_done;

  int n_cmp = 0;
  int n_err = 0;
  int elem [64];
  logic [63:0] exp_q [$];
  logic [7:0]  exp_a [$];
  logic [63:0] acc_d [$];
  logic [7:0]  acc_a [$];
  logic        mon_en = 1'b0;
  logic        held_v = 1'b0;
  logic [7:0]  held_a;
  logic [63:0] held_d;

  matrix_result_writeback_if #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) mem_if ();

  matrix_result_writeback #(.ACCUMULATOR_WIDTH(24), .ADDR_WIDTH(8), .DATA_WIDTH(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_start     (wb_start),
    .wb_base_addr (wb_base_addr),
    .mat_res      (mat_res),
    .wb_busy      (wb_busy),
    .wb_done      (wb_done),
    .mem          (mem_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Expected word k from the element values.
  function automatic logic [63:0] model_word(input int k);
    logic [63:0] w = '0;
`ifdef FMA_WB_SAT8_EN
    for (int c = 0; c < 8; c++) begin
      int v;
      v = elem[k*8+c];
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      w[c*8 +: 8] = v[7:0];
    end
`else
    for (int b = 0; b < 64; b++) begin
      int g;
      g = k*64 + b;
      w[b] = elem[g/24][g%24];
    end
`endif
    return w;
  endfunction

  task automatic set_mat();
    for (int e = 0; e < 64; e++) mat_res[e*24 +: 24] = elem[e][23:0];
  endtask

  // Scoreboard: every accepted write must be the next expected one; a stalled
  // word must stay put (address, data, we) into the following cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (held_v) begin
        chk("stall_we",   {63'd0, mem_if.dpmem_we_a}, 64'd1);
        chk("stall_addr", {56'd0, mem_if.dpmem_addr_a}, {56'd0, held_a});
        chk("stall_data", mem_if.dpmem_din_a, held_d);
        held_v = 1'b0;
      end
      if (mem_if.dpmem_we_a === 1'b1) begin
        if (mem_if.dpmem_wr_ready !== 1'b1) begin
          held_v = 1'b1;
          held_a = mem_if.dpmem_addr_a;
          held_d = mem_if.dpmem_din_a;
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write",
                   mem_if.dpmem_addr_a, mem_if.dpmem_din_a);
        end else begin
          chk("wr_addr", {56'd0, mem_if.dpmem_addr_a}, {56'd0, exp_a[0]});
          chk("wr_data", mem_if.dpmem_din_a, exp_q[0]);
          acc_a.push_back(mem_if.dpmem_addr_a);
          acc_d.push_back(mem_if.dpmem_din_a);
          void'(exp_q.pop_front());
          void'(exp_a.pop_front());
        end
      end
    end
  end

  // One burst: cycle n is the n-th cycle after the start edge. exp_done = 0
  // means no wb_done is expected (abort run).
  task automatic run_burst(input string nm, input logic [7:0] base, input int stall_at,
                           input int stall_len, input bit inject, input int abort_at,
                           input int exp_done);
    int done_n = 0;
    bit busy_ok = 1'b1;
    int lim = (exp_done > 0) ? exp_done + 20 : abort_at + 10;
    exp_q.delete(); exp_a.delete(); acc_d.delete(); acc_a.delete();
    for (int k = 0; k < NW; k++) begin
      exp_q.push_back(model_word(k));
      exp_a.push_back(base + 8'(k));
    end
    wb_base_addr = base;
    wb_start = 1'b1;
    @(posedge clk); #1;
    wb_start = 1'b0;
    for (int n = 1; n <= lim; n++) begin
      mem_if.dpmem_wr_ready = !(n >= stall_at && n < stall_at + stall_len);
      if (inject && n == 3) begin
        wb_start = 1'b1;
        wb_base_addr = base + 8'h40;
        for (int e = 0; e < 64; e++) elem[e] = -1000 * e - 7;
        set_mat();
      end
      if (inject && n == 5) wb_start = 1'b0;
      if (abort_at > 0 && n == abort_at) reset = 1'b1;
      if (abort_at > 0 && n == abort_at + 1) reset = 1'b0;
      @(negedge clk);
      if (abort_at > 0 && n > abort_at) begin
        chk({nm, "_abort_we"},   {63'd0, mem_if.dpmem_we_a}, 64'd0);
        chk({nm, "_abort_busy"}, {63'd0, wb_busy}, 64'd0);
      end
      if (wb_done === 1'b1 && done_n == 0) done_n = n;
      else if (wb_busy !== 1'b1 && abort_at == 0) busy_ok = 1'b0;
      if (done_n != 0) break;
      @(posedge clk); #1;
    end
    mem_if.dpmem_wr_ready = 1'b1;
    chk({nm, "_done_cycle"}, 64'(done_n), 64'(exp_done));
    if (exp_done > 0) begin
      chk({nm, "_busy_during"}, {63'd0, busy_ok}, 64'd1);
      chk({nm, "_writes"}, 64'(acc_d.size()), 64'(NW));
      @(posedge clk); #1;
      @(negedge clk);
      chk({nm, "_done_pulse"}, {63'd0, wb_done}, 64'd0);
      chk({nm, "_busy_after"}, {63'd0, wb_busy}, 64'd0);
      chk({nm, "_we_after"},   {63'd0, mem_if.dpmem_we_a}, 64'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    mem_if.dpmem_wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, wb_busy}, 64'd0);
    chk("rst_done", {63'd0, wb_done}, 64'd0);
    chk("rst_we",   {63'd0, mem_if.dpmem_we_a}, 64'd0);
    chk("rst_addr", {56'd0, mem_if.dpmem_addr_a}, 64'd0);
    chk("rst_data", mem_if.dpmem_din_a, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Basic burst, element (r,c) = r*8+c.
    for (int e = 0; e < 64; e++) elem[e] = e;
    set_mat();
    run_burst("basic", 8'h10, 0, 0, 1'b0, 0, NW + 1);
    if (acc_d.size() >= NW) begin
      chk("pin_w0",    acc_d[0], PIN_W0);
      chk("pin_w1",    acc_d[1], PIN_W1);
      chk("pin_a0",    {56'd0, acc_a[0]}, 64'h10);
      chk("pin_alast", {56'd0, acc_a[NW-1]}, {56'd0, PIN_LASTA});
    end

    // Backpressure at k=5 for 3 cycles.
    for (int e = 0; e < 64; e++) elem[e] = e * 37 - 900;
    set_mat();
    run_burst("stall", 8'h10, 6, 3, 1'b0, 0, NW + 4);
    if (acc_a.size() > 5) chk("pin_stall_a5", {56'd0, acc_a[5]}, 64'h15);

    // Address wrap.
    run_burst("wrap", WRAP_BASE, 0, 0, 1'b0, 0, NW + 1);
    if (acc_a.size() >= NW) begin
      chk("pin_wrap_ff", {56'd0, acc_a[WRAP_IDX0-1]}, 64'hFF);
      chk("pin_wrap_00", {56'd0, acc_a[WRAP_IDX0]}, 64'h00);
    end

    // Second start during WRITE plus mat_res change: ignored.
    for (int e = 0; e < 64; e++) elem[e] = 5000 - e * 91;
    set_mat();
    run_burst("inject", 8'h30, 0, 0, 1'b1, 0, NW + 1);

    // Reset mid-burst at k=10, then a fresh complete burst.
    for (int e = 0; e < 64; e++) elem[e] = e * 131 + 3;
    set_mat();
    run_burst("abort", 8'h50, 0, 0, 1'b0, 11, 0);
    run_burst("after_abort", 8'h80, 0, 0, 1'b0, 0, NW + 1);

    // Row 0 = 58, 300, -500, -5; rest zero.
    for (int e = 0; e < 64; e++) elem[e] = 0;
    elem[0] = 58; elem[1] = 300; elem[2] = -500; elem[3] = -5;
    set_mat();
    run_burst("neg", 8'h00, 0, 0, 1'b0, 0, NW + 1);
    if (acc_d.size() > 0) chk("pin_neg_w0", acc_d[0], PIN_NEG);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/matrix_result_writeback.md
Name: matrix_result_writeback

Overview:
- Write-side counterpart of the FMA's matrix-B memory read port.
- Captures the 64-element, 24-bit FMA result matrix in one cycle and streams it into the dual-port memory as 64-bit words over write port A, honouring memory backpressure.
- Sits between matrix_fma_8x8's mat_out/fma_done and the dpmem.
- Written results can be read back later as operands or by the host.

Parameters:
ACCUMULATOR_WIDTH, 24, element width in the result vector (fixed layout assumes 24)
ADDR_WIDTH, 8, memory word-address width
DATA_WIDTH, 64, memory word width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wb_start  in  1  capture pulse (tie to fma_done); sampled only in IDLE
wb_base_addr  in  ADDR_WIDTH  first destination word address, captured with wb_start
mat_res  in  1536  result matrix; element (r,c) at bits [(r*8+c)*24 +: 24]
wb_busy  out  1  high in WRITE and DONE states
wb_done  out  1  one-cycle pulse after last word accepted
dpmem_addr_a  out  ADDR_WIDTH  write address
dpmem_din_a  out  DATA_WIDTH  write data
dpmem_we_a  out  1  write request
dpmem_wr_ready  in  1  memory accepts the word when dpmem_we_a && dpmem_wr_ready

Behaviour:
- One clock. Reset is synchronous and active-high.
- On reset, all outputs are 0, state is IDLE, and word counter and capture register are cleared.
- Reset asserted mid-burst aborts the burst: dpmem_we_a is low from the next edge, and no wb_done pulse is produced.
- States:
  - IDLE: wb_start=1 at edge N latches mat_res, wb_base_addr and word counter k=0; go to WRITE. wb_start outside IDLE is ignored, so no queueing.
  - WRITE: dpmem_we_a=1 from cycle N+1. dpmem_addr_a = (base+k) mod 2^ADDR_WIDTH; the address wraps 255->0 with no error. dpmem_din_a = word k.
    - If dpmem_wr_ready=0: address and data are held stable and we stays high.
    - On acceptance: k increments.
    - On acceptance of the last word: go to DONE, and we drops on that edge.
  - DONE: one cycle. wb_done=1, wb_busy=1. Then return to IDLE.
- Raw mode (default): 24 words. Word k = captured[k*64 +: 64]. Elements straddle word boundaries.
- Latency with ready held high:
  - Raw mode: the first write is in the cycle after the start edge, then one word per cycle. wb_done occurs in cycle N+25.
- Captured data is isolated from mat_res changes after the start edge.

Optional Feature:
- Macro FMA_WB_SAT8_EN.
- When defined: each element is saturated to signed 8-bit, clamping to +127 if above and -128 if below.
  - Row r is packed into word r with element c at bits [c*8 +: 8]. This is the same layout the FMA reads for matrix B, so results can be chained as the next B operand.
  - 8 words are written; wb_done occurs in cycle N+9 with ready held high.
- When undefined: raw 24-word mode, and no saturation logic is present.

Test Plan:
- Reset, then wb_start with base=0x10 and mat_res element(r,c)=r*8+c, ready=1 -> 24 consecutive writes at 0x10..0x27; word contents match bit slices; wb_done in cycle N+25; wb_busy low afterwards.
- Backpressure: ready low for 3 cycles at k=5 -> address 0x15 and data held stable for 4 cycles, total writes still 24, wb_done delayed 3 cycles.
- Wrap: base=0xF0 -> addresses 0xF0..0xFF then 0x00..0x07; no write outside that set.
- Second wb_start during WRITE, with mat_res changed after capture -> ignored; written data equals the first capture; only 24 writes.
- Reset asserted at k=10 -> we=0 next cycle, no wb_done; a fresh wb_start then completes a full 24-word burst.
- FMA_WB_SAT8_EN defined, elements 58, 300, -500, -5 in row 0 -> word 0 bytes 0x3A, 0x7F, 0x80, 0xFB; 8 writes total; wb_done in cycle N+9.
